// File: rtl/avr_pkg.sv
// Shared definitions for the AVR program-side fetch path.
//   AVR_PC_W      : default program-word address width
//   AVR_NOP       : instruction word presented when nothing is valid
//   AVR_RESET_VEC : default fetch PC after reset
//   fifo_entry_t  : prefetch FIFO entry layout at the default address width
package avr_pkg;

    localparam int          AVR_PC_W      = 16;
    localparam logic [15:0] AVR_NOP       = 16'h0000;
    localparam int unsigned AVR_RESET_VEC = 32'd0;

    typedef struct packed {
        logic [AVR_PC_W-1:0] addr;
        logic [15:0]         word;
    } fifo_entry_t;

endpackage

// File: rtl/avr_ifetch_fifo.sv
// Prefetch FIFO: DEPTH-entry synchronous FIFO with clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous flush, dominates push and pop
//   push, din  : write request and entry at the tail
//   pop        : advance head
//   head       : entry at the head (undefined content when empty)
//   count      : current occupancy 0..DEPTH
//   empty      : count == 0
// A push on a full FIFO is accepted only together with a pop, and a pop on
// an empty FIFO is ignored, so occupancy can never leave 0..DEPTH.
module avr_ifetch_fifo
    import avr_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          push_ok_s;
    logic          pop_ok_s;

    // Qualify requests against current occupancy.
    always_comb begin
        full_s    = (count_r == CW'(DEPTH));
        pop_ok_s  = pop & (count_r != {CW{1'b0}});
        push_ok_s = push & (~full_s | pop_ok_s);
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else if (push_ok_s && !clear) begin
            mem_r[wr_ptr_r] <= din;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Head and status outputs straight from registers.
    always_comb begin
        head  = mem_r[rd_ptr_r];
        count = count_r;
        empty = (count_r == {CW{1'b0}});
    end

endmodule

// File: rtl/avr_ifetch.sv
// AVR instruction-fetch responder.
// Issues sequential reads to a 1-cycle-latency synchronous program ROM,
// buffers returned words in a prefetch FIFO and hands them to the core over
// a valid/ready handshake. A redirect flushes the FIFO, discards the return
// arriving in the redirect cycle, and issues the target read immediately.
//   CLK, RST   : clock, asynchronous active-low reset
//   p_addr     : redirect target, used when redir=1
//   redir      : redirect strobe
//   instr_rdy  : core accepts instr this cycle
//   instr      : word at FIFO head, AVR_NOP when nothing valid
//   instr_addr : word address of instr (holds last value when empty)
//   instr_vld  : instr/instr_addr valid
//   mem_addr   : ROM read address
//   mem_rd     : ROM read strobe
//   mem_rdata  : ROM data, valid the cycle after mem_rd
// Optional build macro AVR_IFETCH_BYPASS_EN: a return arriving while the
// FIFO is empty is presented to the core in the same cycle, and is not
// stored when the core takes it.
module avr_ifetch
    import avr_pkg::*;
#(
    parameter int          PC_W      = AVR_PC_W,
    parameter int          DEPTH     = 2,
    parameter int unsigned RESET_VEC = AVR_RESET_VEC
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PC_W-1:0] p_addr,
    input  logic            redir,
    input  logic            instr_rdy,
    output logic [15:0]     instr,
    output logic [PC_W-1:0] instr_addr,
    output logic            instr_vld,
    output logic [PC_W-1:0] mem_addr,
    output logic            mem_rd,
    input  logic [15:0]     mem_rdata
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = PC_W + 16;

    typedef struct packed {
        logic [PC_W-1:0] addr;
        logic [15:0]     word;
    } entry_t;

    logic [PC_W-1:0] pc_r;
    logic            inflight_r;
    logic [PC_W-1:0] ret_addr_r;
    logic [PC_W-1:0] last_addr_r;

    entry_t          fifo_din_s;
    entry_t          fifo_head_s;
    logic [EW-1:0]   fifo_head_raw_s;
    logic [CW-1:0]   fifo_count_s;
    logic            fifo_empty_s;
    logic            fifo_push_s;
    logic            fifo_pop_s;

    logic            ret_vld_s;
    logic            byp_s;
    logic            pop_s;
    logic [CW:0]     occ_s;
    logic            issue_s;
    logic [PC_W-1:0] mem_addr_s;
    logic [15:0]     instr_s;
    logic [PC_W-1:0] instr_addr_s;
    logic            instr_vld_s;

    avr_ifetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .clear (redir),
        .push  (fifo_push_s),
        .din   (fifo_din_s),
        .pop   (fifo_pop_s),
        .head  (fifo_head_raw_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    // Return qualification; a return in the redirect cycle belongs to the
    // abandoned stream and is dropped.
    always_comb begin
        ret_vld_s  = inflight_r & ~redir;
        fifo_din_s = '{addr: ret_addr_r, word: mem_rdata};
        fifo_head_s = entry_t'(fifo_head_raw_s);
`ifdef AVR_IFETCH_BYPASS_EN
        byp_s = ret_vld_s & fifo_empty_s;
`else
        byp_s = 1'b0;
`endif
    end

    // Core-facing word selection: bypassed return, FIFO head, or NOP.
    always_comb begin
        if (byp_s) begin
            instr_s      = mem_rdata;
            instr_addr_s = ret_addr_r;
            instr_vld_s  = 1'b1;
        end else if (!fifo_empty_s) begin
            instr_s      = fifo_head_s.word;
            instr_addr_s = fifo_head_s.addr;
            instr_vld_s  = 1'b1;
        end else begin
            instr_s      = AVR_NOP;
            instr_addr_s = last_addr_r;
            instr_vld_s  = 1'b0;
        end
    end

    // Handshake, FIFO control and issue decision.
    // occ_s is the occupancy after this edge if nothing new is issued; it
    // cannot go negative because a pop needs either a stored word or a
    // bypassed in-flight return. Redirect always issues: the FIFO is being
    // cleared and the in-flight return is discarded.
    always_comb begin
        pop_s       = instr_vld_s & instr_rdy;
        fifo_pop_s  = pop_s & ~fifo_empty_s & ~redir;
        fifo_push_s = ret_vld_s & ~(byp_s & instr_rdy);
        occ_s       = {1'b0, fifo_count_s} + (CW+1)'(inflight_r) - (CW+1)'(pop_s);
        mem_addr_s  = redir ? p_addr : pc_r;
        issue_s     = RST & (redir | (occ_s < (CW+1)'(DEPTH)));
    end

    // Fetch PC, in-flight tracking and held return address.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_r        <= PC_W'(RESET_VEC);
            inflight_r  <= 1'b0;
            ret_addr_r  <= {PC_W{1'b0}};
            last_addr_r <= {PC_W{1'b0}};
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pc_r       <= mem_addr_s + PC_W'(1);
                ret_addr_r <= mem_addr_s;
            end else begin
                pc_r       <= pc_r;
                ret_addr_r <= ret_addr_r;
            end
            if (instr_vld_s) begin
                last_addr_r <= instr_addr_s;
            end else begin
                last_addr_r <= last_addr_r;
            end
        end
    end

    // Output drive.
    always_comb begin
        instr      = instr_s;
        instr_addr = instr_addr_s;
        instr_vld  = instr_vld_s;
        mem_addr   = mem_addr_s;
        mem_rd     = issue_s;
    end

endmodule

// File: tb/tb_avr_ifetch.sv
// Directed self-checking bench for avr_ifetch.
// ROM model: word[a] = a ^ 16'h5000, one-cycle read latency.
module tb_avr_ifetch;

`ifdef AVR_IFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        CLK;
    logic        RST;
    logic [15:0] p_addr;
    logic        redir;
    logic        instr_rdy;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        instr_vld;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;

    int n_asrt;
    int n_fail;

    avr_ifetch #(
        .PC_W      (16),
        .DEPTH     (2),
        .RESET_VEC (0)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .p_addr     (p_addr),
        .redir      (redir),
        .instr_rdy  (instr_rdy),
        .instr      (instr),
        .instr_addr (instr_addr),
        .instr_vld  (instr_vld),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous program ROM.
    initial mem_rdata = 16'h0000;
    always @(posedge CLK) begin
        if (mem_rd) mem_rdata <= mem_addr ^ 16'h5000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_word(input string tag, input logic [15:0] a);
        chk({tag, "_vld"},  32'(instr_vld), 32'd1);
        chk({tag, "_word"}, 32'(instr), 32'(a ^ 16'h5000));
        chk({tag, "_addr"}, 32'(instr_addr), 32'(a));
    endtask

    // Called in the cycle that must issue address a (redirect or reset
    // release); checks the issue, the empty latency cycles, then n words.
    task automatic fetch_from(input logic [15:0] a, input int n);
        logic [15:0] k;
        chk("issue_rd",   32'(mem_rd), 32'd1);
        chk("issue_addr", 32'(mem_addr), 32'(a));
        for (int i = 1; i < LAT; i++) begin
            tick(); redir = 1'b0; settle();
            chk("lat_vld", 32'(instr_vld), 32'd0);
            chk("lat_nop", 32'(instr), 32'h0000);
        end
        k = a;
        for (int i = 0; i < n; i++) begin
            tick(); redir = 1'b0; settle();
            expect_word("stream", k);
            k = k + 16'd1;
        end
    endtask

    initial begin
        n_asrt    = 0;
        n_fail    = 0;
        RST       = 1'b0;
        redir     = 1'b0;
        instr_rdy = 1'b0;
        p_addr    = 16'h0000;

        // Reset state.
        #2;
        chk("rst_instr",    32'(instr), 32'h0000);
        chk("rst_addr",     32'(instr_addr), 32'h0000);
        chk("rst_vld",      32'(instr_vld), 32'd0);
        chk("rst_mem_rd",   32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0000);

        // Release and stream words 0..5.
        tick(); tick();
        RST = 1'b1; instr_rdy = 1'b1;
        settle();
        fetch_from(16'h0000, 6);

        // Stall on word 5 for six cycles; reads stop once the FIFO is full.
        instr_rdy = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick(); settle();
            expect_word("stall", 16'h0005);
            if (c >= 2) chk("stall_no_rd", 32'(mem_rd), 32'd0);
        end
        instr_rdy = 1'b1;
        settle();
        for (int k = 6; k <= 9; k++) begin
            tick(); settle();
            expect_word("resume", 16'(k));
        end

        // Redirect mid-stream.
        redir = 1'b1; p_addr = 16'h0040;
        settle();
        fetch_from(16'h0040, 3);

        // Redirect to the top of the address space; PC wraps.
        redir = 1'b1; p_addr = 16'hFFFF;
        settle();
        fetch_from(16'hFFFF, 3);

        // Short asynchronous reset mid-stream.
        tick();
        RST = 1'b0;
        settle();
        chk("mid_rst_instr",    32'(instr), 32'h0000);
        chk("mid_rst_addr",     32'(instr_addr), 32'h0000);
        chk("mid_rst_vld",      32'(instr_vld), 32'd0);
        chk("mid_rst_mem_rd",   32'(mem_rd), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr), 32'h0000);
        #1;
        RST = 1'b1;
        #1;
        fetch_from(16'h0000, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
